// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_if
//  Purpose  : Request/result bundle between a requester and serial_subtractor.
//             The requester drives start and the operands. The subtractor
//             returns busy/done and the held difference with its borrow-out.
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;  // request, only honoured while the subtractor idles
  logic [WIDTH-1:0] A;      // minuend
  logic [WIDTH-1:0] B;      // subtrahend
  logic             Bin;    // borrow-in
  logic             busy;   // high while bits are being processed
  logic             done;   // one-cycle pulse: D/Bout freshly updated
  logic [WIDTH-1:0] D;      // difference, held until the next completion
  logic             Bout;   // final borrow, held with D

  modport master (
    output start, A, B, Bin,
    input  busy, done, D, Bout
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, Bout
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial borrow-ripple subtractor. It computes
//             D = (A - B - Bin) mod 2^WIDTH, one bit per clock, LSB first.
//             One full-subtractor cell is reused on every cycle.
//  Options  : SERIAL_SUB_SAT_EN - when defined, a result that would borrow
//             out is clamped to zero. Bout still reports the borrow.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 4  // must match the WIDTH of the connected interface
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_subtractor_if.slave    bus
);

  // Bit counter just wide enough to index WIDTH bit positions (WIDTH >= 2).
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // captured minuend, shifted right each bit
  logic [WIDTH-1:0] b_q, b_d;        // captured subtrahend, shifted right each bit
  logic             br_q, br_d;      // running borrow
  logic [WIDTH-1:0] res_q, res_d;    // partial result, filled from the MSB side
  logic [CW-1:0]    cnt_q, cnt_d;    // index of the bit processed next
  logic [WIDTH-1:0] dout_q, dout_d;  // visible difference
  logic             bout_q, bout_d;  // visible borrow-out

  // Full-subtractor cell working on the current LSB of both operands.
  logic             bit_a, bit_b, bit_d, bit_br;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] final_d;

  assign bit_a  = a_q[0];
  assign bit_b  = b_q[0];
  assign bit_d  = bit_a ^ bit_b ^ br_q;
  assign bit_br = (~bit_a & bit_b) | (~bit_a & br_q) | (bit_b & br_q);

  // The new bit enters at the MSB. After WIDTH shifts, the first bit produced
  // (the LSB of the difference) has moved down to position 0.
  assign res_shift = {bit_d, res_q[WIDTH-1:1]};

`ifdef SERIAL_SUB_SAT_EN
  // Unsigned saturation: an underflowing result clamps to zero.
  assign final_d = bit_br ? '0 : res_shift;
`else
  // Wrapped modulo-2^WIDTH result.
  assign final_d = res_shift;
`endif

  // FSM state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers. They are cleared by reset, so an aborted run leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      res_q  <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      bout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      br_q   <= br_d;
      res_q  <= res_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      bout_q <= bout_d;
    end
  end

  // Next-state and datapath update. Every register holds unless its state acts on it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    bout_d  = bout_q;

    case (state_q)
      ST_IDLE: begin
        // Operands are sampled only here. A start that arrives in any other
        // state is not queued.
        if (bus.start) begin
          state_d = ST_SHIFT;
          a_d     = bus.A;
          b_d     = bus.B;
          br_d    = bus.Bin;
          res_d   = '0;
          cnt_d   = '0;
        end
      end

      ST_SHIFT: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = bit_br;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // The last bit is being processed. The outputs are loaded directly
          // from the cell, so D/Bout change exactly at this edge.
          state_d = ST_DONE;
          dout_d  = final_d;
          bout_d  = bit_br;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = (state_q == ST_DONE);
  assign bus.D    = dout_q;
  assign bus.Bout = bout_q;

endmodule
`default_nettype wire
